move_request_sequencer: RTL

//   Front-end controller for board_validator. Arbitrates move requests from two

---
 rtl/move_request_sequencer_if.sv | 48 ++++
 rtl/move_request_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/move_request_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : move_request_sequencer_if
// Description : Request, validator and verdict bundle for move_request_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface move_request_sequencer_if;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][2:0] req_old_x;
    logic [1:0][2:0] req_old_y;
    logic [1:0][2:0] req_new_x;
    logic [1:0][2:0] req_new_y;
    logic [1:0][3:0] req_piece;

    logic [2:0]      val_old_x;
    logic [2:0]      val_old_y;
    logic [2:0]      val_new_x;
    logic [2:0]      val_new_y;
    logic [3:0]      val_piece;
    logic            val_start;
    logic            val_done;
    logic            val_ok;

    logic            resp_valid;
    logic            resp_id;
    logic            resp_ok;
    logic [1:0]      resp_code;
    logic            commit;
    logic            side_to_move;

    modport master (
        output req_valid, req_old_x, req_old_y, req_new_x, req_new_y, req_piece,
        output val_done, val_ok,
        input  req_ready,
        input  val_old_x, val_old_y, val_new_x, val_new_y, val_piece, val_start,
        input  resp_valid, resp_id, resp_ok, resp_code, commit, side_to_move
    );

    modport slave (
        input  req_valid, req_old_x, req_old_y, req_new_x, req_new_y, req_piece,
        input  val_done, val_ok,
        output req_ready,
        output val_old_x, val_old_y, val_new_x, val_new_y, val_piece, val_start,
        output resp_valid, resp_id, resp_ok, resp_code, commit, side_to_move
    );
endinterface
`default_nettype wire

// File: rtl/move_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : move_request_sequencer
// Description : Arbitrates two move sources, pre-checks, runs one validation
//               and returns the verdict with a commit strobe on legal moves.
// Revision    : 1.0 - initial release
// ============================================================================
module move_request_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    move_request_sequencer_if.slave  bus
);

    localparam int CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    // Last WAIT cycle sits TIMEOUT_CYCLES-1 after val_start, so the forced
    // reject lands exactly TIMEOUT_CYCLES cycles after the launch pulse.
    localparam int C_CNT_LAST = (TIMEOUT_CYCLES >= 2) ? (TIMEOUT_CYCLES - 2) : 0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

    localparam logic [1:0] CODE_OK      = 2'd0;
    localparam logic [1:0] CODE_RULE    = 2'd1;
    localparam logic [1:0] CODE_PRECHK  = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    logic [2:0]       r_state;
    logic             r_rr_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_old_x;
    logic [2:0]       r_old_y;
    logic [2:0]       r_new_x;
    logic [2:0]       r_new_y;
    logic [3:0]       r_piece;
    logic             r_resp_id;
    logic             r_ok;
    logic [1:0]       r_code;
    logic             r_side;

    logic w_any;
    logic w_grant;
    logic w_precheck_fail;
    logic w_expire;

    assign w_any   = |bus.req_valid;
    assign w_grant = (&bus.req_valid) ? r_rr_ptr : bus.req_valid[1];

    assign w_precheck_fail = (r_piece >= 4'd12)
                          || ((r_piece >= 4'd6) != r_side)
                          || ((r_old_x == r_new_x) && (r_old_y == r_new_y));

    assign w_expire = (r_cnt == CNT_W'(C_CNT_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= 1'b0;
            r_cnt     <= '0;
            r_old_x   <= '0;
            r_old_y   <= '0;
            r_new_x   <= '0;
            r_new_y   <= '0;
            r_piece   <= '0;
            r_resp_id <= 1'b0;
            r_ok      <= 1'b0;
            r_code    <= CODE_OK;
            r_side    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_old_x   <= bus.req_old_x[w_grant];
                        r_old_y   <= bus.req_old_y[w_grant];
                        r_new_x   <= bus.req_new_x[w_grant];
                        r_new_y   <= bus.req_new_y[w_grant];
                        r_piece   <= bus.req_piece[w_grant];
                        r_resp_id <= w_grant;
                        r_rr_ptr  <= ~w_grant;
                        r_state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (w_precheck_fail) begin
                        r_ok    <= 1'b0;
                        r_code  <= CODE_PRECHK;
                        r_state <= ST_RESP;
                    end else begin
                        r_state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A verdict arriving on the expiry cycle takes priority.
                    if (bus.val_done) begin
                        r_ok    <= bus.val_ok;
                        r_code  <= bus.val_ok ? CODE_OK : CODE_RULE;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_expire) begin
                            r_ok    <= 1'b0;
                            r_code  <= CODE_TIMEOUT;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (r_ok) begin
                        r_side <= ~r_side;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = ((r_state == ST_IDLE) && w_any) ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.val_old_x    = r_old_x;
    assign bus.val_old_y    = r_old_y;
    assign bus.val_new_x    = r_new_x;
    assign bus.val_new_y    = r_new_y;
    assign bus.val_piece    = r_piece;
    assign bus.val_start    = (r_state == ST_LAUNCH);
    assign bus.resp_valid   = (r_state == ST_RESP);
    assign bus.resp_id      = r_resp_id;
    assign bus.resp_ok      = (r_state == ST_RESP) && r_ok;
    assign bus.resp_code    = (r_state == ST_RESP) ? r_code : CODE_OK;
    assign bus.commit       = (r_state == ST_RESP) && r_ok;
    assign bus.side_to_move = r_side;

endmodule
`default_nettype wire
